// File: rtl/par_gen.sv
// Registered 3-input parity generator with valid flag; one cycle of latency.
// Optional saturating count of captured '1' results when PAR_GEN_STATS_EN is defined.
module par_gen #(
    parameter int ODD_PARITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        x,
    input  logic        y,
    input  logic        z,
    output logic        result,
    output logic        result_vld
`ifdef PAR_GEN_STATS_EN
    ,
    output logic [15:0] stat_cnt
`endif
);

    localparam logic SENSE = (ODD_PARITY != 0);

    logic par_p0;
    logic result_p1;
    logic vld_p1;

    // stage 0: combinational parity of the sampled bits
    assign par_p0 = x ^ y ^ z ^ SENSE;

    // stage 1: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= en;
            if (en) begin
                result_p1 <= par_p0;
            end
        end
    end

    assign result     = result_p1;
    assign result_vld = vld_p1;

`ifdef PAR_GEN_STATS_EN
    logic [15:0] cnt_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // counts captures whose new parity bit is 1, updated alongside result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= 16'd0;
        end else if (en && par_p0) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign stat_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_par_gen.sv
// Directed self-checking bench for par_gen: even and odd instances driven in parallel.
module tb_par_gen;

    logic clk = 1'b0;
    logic rst, en, x, y, z;
    logic res_e, vld_e, res_o, vld_o;
`ifdef PAR_GEN_STATS_EN
    logic [15:0] cnt_e, cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] even_tbl = 8'b1001_0110;  // bit i = parity of xyz == i

    always #5 clk = ~clk;

    par_gen #(.ODD_PARITY(0)) dut_e (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z),
        .result(res_e), .result_vld(vld_e)
`ifdef PAR_GEN_STATS_EN
        , .stat_cnt(cnt_e)
`endif
    );

    par_gen #(.ODD_PARITY(1)) dut_o (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z),
        .result(res_o), .result_vld(vld_o)
`ifdef PAR_GEN_STATS_EN
        , .stat_cnt(cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic [2:0] v);
        rst = r;
        en  = e;
        x   = v[2];
        y   = v[1];
        z   = v[0];
    endtask

    task automatic check_out(input string tag, input logic re, input logic ro, input logic v);
        check({tag, "_res_even"}, {15'd0, res_e}, {15'd0, re});
        check({tag, "_res_odd"},  {15'd0, res_o}, {15'd0, ro});
        check({tag, "_vld_even"}, {15'd0, vld_e}, {15'd0, v});
        check({tag, "_vld_odd"},  {15'd0, vld_o}, {15'd0, v});
    endtask

    initial begin
        logic [2:0] v;
        logic       p;

        // reset held two cycles with en=1, xyz=111
        set_in(1'b1, 1'b1, 3'b111);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("reset", 1'b0, 1'b0, 1'b0);
`ifdef PAR_GEN_STATS_EN
            check("reset_cnt_even", cnt_e, 16'd0);
            check("reset_cnt_odd",  cnt_o, 16'd0);
`endif
        end

        // exhaustive sweep, each vector held 10 cycles
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            p = even_tbl[k];
            set_in(1'b0, 1'b1, v);
            for (int c = 0; c < 10; c++) begin
                tick();
                check_out($sformatf("sweep%0d", k), p, ~p, 1'b1);
            end
        end

        // enable hold
        set_in(1'b0, 1'b1, 3'b001);
        tick();
        check_out("hold_cap", 1'b1, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 3'b011);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_out("hold", 1'b1, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick();
        check_out("hold_rel", 1'b0, 1'b1, 1'b1);

        // reset mid-stream
        set_in(1'b0, 1'b1, 3'b001);
        tick();
        check_out("mid_pre", 1'b1, 1'b0, 1'b1);
        set_in(1'b1, 1'b1, 3'b001);
        tick();
        check_out("mid_rst", 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 3'b100);
        tick();
        check_out("mid_post", 1'b1, 1'b0, 1'b1);

`ifdef PAR_GEN_STATS_EN
        set_in(1'b1, 1'b0, 3'b000);
        tick();
        check("stat_clr", cnt_e, 16'd0);
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 1'b1, 3'(k));
            tick();
        end
        check("stat_sweep_even", cnt_e, 16'd4);
        check("stat_sweep_odd",  cnt_o, 16'd4);
        set_in(1'b0, 1'b0, 3'b001);
        tick();
        tick();
        check("stat_hold", cnt_e, 16'd4);
        set_in(1'b0, 1'b1, 3'b001);
        for (int c = 0; c < 65530; c++) tick();
        check("stat_near_sat", cnt_e, 16'hFFFE);
        for (int c = 0; c < 4470; c++) tick();
        check("stat_sat_even", cnt_e, 16'hFFFF);
        check("stat_sat_odd",  cnt_o, 16'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/par_gen.md
Name:
par_gen

Overview:
- 3-bit parity generator for single-bit control/status fields x, y, z. It produces a parity bit so that the four bits {x, y, z, result} have even parity, or odd parity when configured.
- The output is registered, with one cycle of latency and a qualifying valid flag.
- Sits at the edge of narrow sideband paths feeding a downstream parity checker.

Parameters:
- ODD_PARITY, 0, parity sense. 0 = even parity (result = x^y^z). 1 = odd parity (result = ~(x^y^z)).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  sample enable; inputs are captured on clk edges where en=1.
- x  input  1  data bit 0.
- y  input  1  data bit 1.
- z  input  1  data bit 2.
- result  output  1  registered parity bit.
- result_vld  output  1  high for one cycle after each enabled capture.
- stat_cnt  output  16  count of captures with result=1. Present only when PAR_GEN_STATS_EN is defined.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All state updates on the rising edge of clk. No combinational path from any input to any output.
- Reset: when rst=1 at a clk edge:
  - result <= 0
  - result_vld <= 0
  - stat_cnt <= 0 (if present)
  - rst dominates en.
- Capture: when rst=0 and en=1 at an edge:
  - result <= x ^ y ^ z ^ ODD_PARITY
  - result_vld <= 1
- Hold: when rst=0 and en=0:
  - result holds its previous value.
  - result_vld <= 0.
- Latency: exactly 1 cycle from the sampling edge to result/result_vld.
- Back-to-back captures on consecutive cycles are allowed. result_vld then stays high continuously.
- Even-mode truth table (x y z -> result): 000->0, 001->1, 010->1, 011->0, 100->1, 101->0, 110->0, 111->1. Odd mode inverts every entry.
- Inputs are treated as synchronous to clk. No internal synchronizers.
- X/Z on inputs during a capture propagates to result. The bench must drive known values whenever en=1.
- Reset asserted mid-stream clears the outputs at that same edge. The first capture after deassertion behaves normally.

Optional Feature:
- Macro: PAR_GEN_STATS_EN.
- Defined:
  - 16-bit stat_cnt increments by 1 at each capture edge where the newly computed parity bit is 1.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared to 0 by rst.
  - Holds when en=0.
  - Updates on the same edge as result.
- Not defined: stat_cnt port and counter logic are absent. Core parity behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1, x=y=z=1 -> result=0, result_vld=0 (stat_cnt=0) throughout.
- Exhaustive even mode: ODD_PARITY=0, en=1, apply xyz=000,001,...,111, each held 10 cycles -> result one cycle later = 0,1,1,0,1,0,0,1; result_vld=1 continuously.
- Odd mode: ODD_PARITY=1, same sweep -> result = 1,0,0,1,0,1,1,0.
- Enable hold: capture xyz=001 (result=1), then en=0 and drive xyz=011 for 5 cycles -> result stays 1, result_vld=0; re-assert en -> result=0 next cycle.
- Reset mid-stream: with result=1, assert rst for 1 cycle while en=1 -> result=0, result_vld=0 that edge; next enabled capture of 100 -> result=1.
- Stats (PAR_GEN_STATS_EN): even-mode 8-vector sweep, one cycle each -> stat_cnt=4. Force 70000 captures of xyz=001 -> stat_cnt saturates at 16'hFFFF.
